// File: rtl/door_sequencer.sv
// Door motor sequencer: drives open/close motor outputs from presence, e-stop and limit
// switches, with auto-close dwell, obstruction reversal via a brake interval, a motor-run
// watchdog and a sticky fault that only reset clears.
module door_sequencer #(
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned MOTOR_TIMEOUT = 5000,
  parameter int unsigned BRAKE_CYCLES  = 50,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ena,
  input  logic       i_sen,
  input  logic       i_se,
  input  logic       i_la,
  input  logic       i_lc,
  output logic       o_ma,
  output logic       o_mc,
  output logic [2:0] o_state,
  output logic       o_fault,
  output logic [3:0] o_rev_cnt
);

  typedef enum logic [2:0] {
    StClosed   = 3'd0,
    StOpening  = 3'd1,
    StOpenHold = 3'd2,
    StClosing  = 3'd3,
    StBrake    = 3'd4,
    StEstop    = 3'd5,
    StFault    = 3'd6,
    StInit     = 3'd7
  } state_e;

  // Terminal timer values: the transition fires on the edge where the timer holds these.
  localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(MOTOR_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BrakeLast   = CNT_W'(BRAKE_CYCLES - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_fault;
  logic [3:0]       r_rev_cnt;

  // State, shared timer, sticky fault and reversal counter; everything freezes while ena=0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StInit;
      r_timer   <= '0;
      r_fault   <= 1'b0;
      r_rev_cnt <= 4'd0;
    end else if (i_ena) begin
      // Default: stay and count; any state change below overrides with a cleared timer.
      if (r_timer != {CNT_W{1'b1}}) r_timer <= r_timer + 1'b1;

      if (r_state == StFault) begin
        r_fault <= 1'b1;
      end else if (i_la && i_lc) begin
        // Both limits at once is physically impossible: treat as a sensor failure.
        r_state <= StFault;
        r_timer <= '0;
        r_fault <= 1'b1;
      end else if (i_se) begin
        if (r_state != StEstop) begin
          r_state <= StEstop;
          r_timer <= '0;
        end
      end else begin
        case (r_state)
          StInit: begin
            r_timer <= '0;
            if (i_lc)      r_state <= StClosed;
            else if (i_la) r_state <= StOpenHold;
            else           r_state <= StClosing;
          end
          StClosed: begin
            if (i_sen) begin
              r_state <= StOpening;
              r_timer <= '0;
            end
          end
          StOpening: begin
            if (i_la) begin
              r_state <= StOpenHold;
              r_timer <= '0;
            end else if (r_timer == TimeoutLast) begin
              r_state <= StFault;
              r_timer <= '0;
              r_fault <= 1'b1;
            end
          end
          StOpenHold: begin
            if (i_sen) begin
              r_timer <= '0;
            end else if (r_timer == HoldLast) begin
              r_state <= StClosing;
              r_timer <= '0;
            end
          end
          StClosing: begin
            // lc wins over sen: a door that is already shut needs no reversal.
            if (i_lc) begin
              r_state <= StClosed;
              r_timer <= '0;
            end else if (i_sen) begin
              r_state <= StBrake;
              r_timer <= '0;
              if (r_rev_cnt != 4'hf) r_rev_cnt <= r_rev_cnt + 4'd1;
            end else if (r_timer == TimeoutLast) begin
              r_state <= StFault;
              r_timer <= '0;
              r_fault <= 1'b1;
            end
          end
          StBrake: begin
            if (r_timer == BrakeLast) begin
              r_state <= StOpening;
              r_timer <= '0;
            end
          end
          StEstop: begin
            r_timer <= '0;
            if (i_sen)     r_state <= StOpening;
            else if (i_lc) r_state <= StClosed;
            else if (i_la) r_state <= StOpenHold;
            else           r_state <= StClosing;
          end
          default: begin
            r_state <= StFault;
            r_timer <= '0;
            r_fault <= 1'b1;
          end
        endcase
      end
    end
  end

  // Motor drives are gated by ena so a frozen sequencer never powers the motor.
  always_comb begin
    o_ma = (r_state == StOpening) && i_ena;
    o_mc = (r_state == StClosing) && i_ena;
  end

  assign o_state   = r_state;
  assign o_fault   = r_fault;
  assign o_rev_cnt = r_rev_cnt;

endmodule

// File: tb/tb_door_sequencer.sv
// Directed bench for door_sequencer with HOLD=8, TIMEOUT=16, BRAKE=2.
module tb_door_sequencer;

  logic       clk = 1'b0;
  logic       rst, ena, sen, se, la, lc;
  logic       ma, mc, fault;
  logic [2:0] state;
  logic [3:0] rev_cnt;

  int total = 0;
  int bad   = 0;

  door_sequencer #(
    .HOLD_CYCLES  (8),
    .MOTOR_TIMEOUT(16),
    .BRAKE_CYCLES (2),
    .CNT_W        (16)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_ena    (ena),
    .i_sen    (sen),
    .i_se     (se),
    .i_la     (la),
    .i_lc     (lc),
    .o_ma     (ma),
    .o_mc     (mc),
    .o_state  (state),
    .o_fault  (fault),
    .o_rev_cnt(rev_cnt)
  );

  always #5 clk = ~clk;

  // Advance n clock edges; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] s, input logic m_a, input logic m_c);
    chk({tag, ".state"}, 16'(state), 16'(s));
    chk({tag, ".ma"}, 16'(ma), 16'(m_a));
    chk({tag, ".mc"}, 16'(mc), 16'(m_c));
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; sen = 1'b0; se = 1'b0; la = 1'b0; lc = 1'b1;
    #1;
    tick();
    chk_st("reset", 3'd7, 1'b0, 1'b0);
    chk("reset.fault", 16'(fault), 16'd0);
    chk("reset.rev", 16'(rev_cnt), 16'd0);

    // INIT -> CLOSED with lc, then open on sen.
    rst = 1'b0;
    tick();
    chk_st("init_closed", 3'd0, 1'b0, 1'b0);
    sen = 1'b1;
    tick();
    chk_st("open_start", 3'd1, 1'b1, 1'b0);
    sen = 1'b0; lc = 1'b0;
    tick();
    chk_st("opening", 3'd1, 1'b1, 1'b0);
    la = 1'b1;
    tick();
    chk_st("open_hold", 3'd2, 1'b0, 1'b0);
    la = 1'b0;

    // Dwell: 8 cycles in OPEN_HOLD, then closing.
    tick(7);
    chk_st("hold7", 3'd2, 1'b0, 1'b0);
    tick();
    chk_st("hold_to_close", 3'd3, 1'b0, 1'b1);
    lc = 1'b1;
    tick();
    chk_st("closed_again", 3'd0, 1'b0, 1'b0);

    // Presence mid-hold restarts the dwell.
    sen = 1'b1;
    tick();
    sen = 1'b0; lc = 1'b0; la = 1'b1;
    tick();
    la = 1'b0;
    chk_st("hold2", 3'd2, 1'b0, 1'b0);
    tick(4);
    sen = 1'b1;
    tick();
    sen = 1'b0;
    tick(7);
    chk_st("hold_restart7", 3'd2, 1'b0, 1'b0);
    tick();
    chk_st("hold_restart_close", 3'd3, 1'b0, 1'b1);

    // Obstruction reversal through BRAKE.
    sen = 1'b1;
    tick();
    sen = 1'b0;
    chk_st("brake1", 3'd4, 1'b0, 1'b0);
    chk("rev1", 16'(rev_cnt), 16'd1);
    tick();
    chk_st("brake2", 3'd4, 1'b0, 1'b0);
    tick();
    chk_st("brake_to_open", 3'd1, 1'b1, 1'b0);
    la = 1'b1;
    tick();
    la = 1'b0;
    tick(8);
    chk_st("back_closing", 3'd3, 1'b0, 1'b1);

    // Further reversals; counter saturates at 15.
    for (int i = 2; i <= 16; i++) begin
      sen = 1'b1;
      tick();
      sen = 1'b0;
      tick(2);
      la = 1'b1;
      tick();
      la = 1'b0;
      tick(8);
      if (i == 15) chk("rev15", 16'(rev_cnt), 16'd15);
    end
    chk("rev_sat", 16'(rev_cnt), 16'd15);
    chk_st("rev_loop_end", 3'd3, 1'b0, 1'b1);

    // ena=0 freezes the CLOSING timer and gates mc; watchdog then fires on schedule.
    tick(3);
    ena = 1'b0;
    tick(5);
    chk_st("frozen", 3'd3, 1'b0, 1'b0);
    ena = 1'b1;
    tick();
    chk_st("resume", 3'd3, 1'b0, 1'b1);
    tick(11);
    chk_st("close_t15", 3'd3, 1'b0, 1'b1);
    tick();
    chk_st("close_timeout", 3'd6, 1'b0, 1'b0);
    chk("close_timeout.fault", 16'(fault), 16'd1);
    se = 1'b1; sen = 1'b1;
    tick();
    chk_st("fault_sticky", 3'd6, 1'b0, 1'b0);
    se = 1'b0; sen = 1'b0;

    // Reset into CLOSING; sen and lc together goes to CLOSED without a reversal.
    rst = 1'b1;
    tick();
    chk("rst2.fault", 16'(fault), 16'd0);
    chk("rst2.rev", 16'(rev_cnt), 16'd0);
    rst = 1'b0;
    tick();
    chk_st("init_closing", 3'd3, 1'b0, 1'b1);
    sen = 1'b1; lc = 1'b1;
    tick();
    chk_st("sen_lc_closed", 3'd0, 1'b0, 1'b0);
    chk("sen_lc_rev", 16'(rev_cnt), 16'd0);

    // Opening watchdog: ma high exactly 16 cycles, then FAULT.
    tick();
    sen = 1'b0; lc = 1'b0;
    chk_st("wd_open0", 3'd1, 1'b1, 1'b0);
    tick(15);
    chk_st("wd_open15", 3'd1, 1'b1, 1'b0);
    tick();
    chk_st("wd_fault", 3'd6, 1'b0, 1'b0);
    chk("wd_fault.flag", 16'(fault), 16'd1);
    se = 1'b1; sen = 1'b1;
    tick();
    chk_st("wd_fault_hold", 3'd6, 1'b0, 1'b0);
    se = 1'b0; sen = 1'b0;

    // Emergency stop during OPENING, release with la=1.
    rst = 1'b1; lc = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    sen = 1'b1;
    tick();
    sen = 1'b0; lc = 1'b0;
    chk_st("es_opening", 3'd1, 1'b1, 1'b0);
    se = 1'b1;
    tick();
    chk_st("estop", 3'd5, 1'b0, 1'b0);
    la = 1'b1;
    tick();
    chk_st("estop_hold", 3'd5, 1'b0, 1'b0);
    se = 1'b0;
    tick();
    chk_st("estop_release", 3'd2, 1'b0, 1'b0);

    // Both limits high -> FAULT.
    lc = 1'b1;
    tick();
    chk_st("both_limits", 3'd6, 1'b0, 1'b0);
    chk("both_limits.fault", 16'(fault), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
